// File: rtl/mux_4to1_rr_arb.sv
// 4:1 registered data mux with round-robin arbitration; 1-cycle grant-to-output latency, one word/cycle when drained.
// Holds o/sel and withholds grants while o_ready=0 in FULL. Define MUX_ARB_FIXED_PRIO_EN for fixed priority (0>1>2>3).
module mux_4to1_rr_arb #(
  parameter int width  = 4,
  parameter int swidth = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [width-1:0]  i0,
  input  logic [width-1:0]  i1,
  input  logic [width-1:0]  i2,
  input  logic [width-1:0]  i3,
  input  logic [3:0]        req,
  output logic [3:0]        gnt,
  output logic [width-1:0]  o,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [swidth-1:0] sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [1:0]         r_ptr;
  logic [width-1:0]   r_o;
  logic [swidth-1:0]  r_sel;
  logic               w_load;
  logic               w_any;
  logic               w_grant;
  logic               w_found;
  logic [1:0]         w_win_idx;
  logic [1:0]         w_cand;
  logic [width-1:0]   w_win_dat;

  assign w_load  = (r_state == EMPTY) || o_ready;
  assign w_any   = |req;
  assign w_grant = w_load && w_any;

`ifdef MUX_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win_idx = 2'd0;
    w_found   = 1'b0;
    w_cand    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!w_found && req[i]) begin
        w_win_idx = 2'(i);
        w_found   = 1'b1;
      end
    end
  end
`else
  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    w_win_idx = 2'd0;
    w_found   = 1'b0;
    w_cand    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_found && req[w_cand]) begin
        w_win_idx = w_cand;
        w_found   = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_win_dat = i0;
    case (w_win_idx)
      2'd0:    w_win_dat = i0;
      2'd1:    w_win_dat = i1;
      2'd2:    w_win_dat = i2;
      default: w_win_dat = i3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_load) begin
      w_next_state = w_any ? FULL : EMPTY;
    end
  end

  always_comb begin
    gnt = 4'b0000;
    if (w_grant && rst_n) begin
      gnt[w_win_idx] = 1'b1;
    end
    o_valid = (r_state == FULL);
    o       = r_o;
    sel     = r_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o   <= '0;
      r_sel <= '0;
      r_ptr <= 2'd3;
    end else if (w_grant) begin
      r_o   <= w_win_dat;
      r_sel <= swidth'(w_win_idx);
      r_ptr <= w_win_idx;
    end
  end

endmodule

// File: tb/tb_mux_4to1_rr_arb.sv
// Directed bench for mux_4to1_rr_arb (round-robin build); expected values are hand-computed per step.
module tb_mux_4to1_rr_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] i0, i1, i2, i3;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] o;
  logic       o_valid;
  logic       o_ready;
  logic [1:0] sel;

  int n_checks = 0;
  int n_pass   = 0;

  mux_4to1_rr_arb #(.width(4), .swidth(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .req(req), .gnt(gnt),
    .o(o), .o_valid(o_valid), .o_ready(o_ready), .sel(sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_o, input logic [1:0] e_sel, input logic e_v);
    check_val({tag, ".o"}, 32'(o), 32'(e_o));
    check_val({tag, ".sel"}, 32'(sel), 32'(e_sel));
    check_val({tag, ".o_valid"}, 32'(o_valid), 32'(e_v));
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; o_ready = 1'b0;
    i0 = 4'hA; i1 = 4'hB; i2 = 4'hC; i3 = 4'hD;
    #3;
    check_out("reset", 4'h0, 2'd0, 1'b0);
    req = 4'b1111; o_ready = 1'b1;
    #1;
    check_val("reset.gnt", 32'(gnt), 32'b0000);
    tick();
    check_val("reset_held.gnt", 32'(gnt), 32'b0000);
    #2 rst_n = 1'b1;
    #1;
    // Round-robin rotation starting at requester 0
    check_val("rr0.gnt", 32'(gnt), 32'b0001);
    tick(); check_out("rr0", 4'hA, 2'd0, 1'b1);
    check_val("rr1.gnt", 32'(gnt), 32'b0010);
    tick(); check_out("rr1", 4'hB, 2'd1, 1'b1);
    check_val("rr2.gnt", 32'(gnt), 32'b0100);
    tick(); check_out("rr2", 4'hC, 2'd2, 1'b1);
    check_val("rr3.gnt", 32'(gnt), 32'b1000);
    tick(); check_out("rr3", 4'hD, 2'd3, 1'b1);

    // Back-pressure: grant 2, stall three cycles, then 3 wins
    req = 4'b0100; #1;
    check_val("bp_g2.gnt", 32'(gnt), 32'b0100);
    tick(); check_out("bp_g2", 4'hC, 2'd2, 1'b1);
    req = 4'b1011; o_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_val("bp_stall.gnt", 32'(gnt), 32'b0000);
      tick(); check_out("bp_stall", 4'hC, 2'd2, 1'b1);
    end
    o_ready = 1'b1; #1;
    check_val("bp_rel.gnt", 32'(gnt), 32'b1000);
    tick(); check_out("bp_rel", 4'hD, 2'd3, 1'b1);

    // Drain to EMPTY, then regrant with no extra bubble
    i1 = 4'hE; req = 4'b0010; #1;
    check_val("dr_g1.gnt", 32'(gnt), 32'b0010);
    tick(); check_out("dr_g1", 4'hE, 2'd1, 1'b1);
    req = 4'b0000; #1;
    check_val("dr_idle.gnt", 32'(gnt), 32'b0000);
    tick(); check_out("dr_empty", 4'hE, 2'd1, 1'b0);
    req = 4'b1000; o_ready = 1'b0; #1;
    check_val("dr_regrant.gnt", 32'(gnt), 32'b1000);
    tick(); check_out("dr_regrant", 4'hD, 2'd3, 1'b1);
    i1 = 4'hB;

    // Single requester streams every cycle
    req = 4'b0100; o_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      i2 = 4'(c); #1;
      check_val("single.gnt", 32'(gnt), 32'b0100);
      tick(); check_out("single", 4'(c), 2'd2, 1'b1);
    end

    // Asynchronous reset pulse while FULL
    #2 rst_n = 1'b0; #1;
    check_out("async_rst", 4'h0, 2'd0, 1'b0);
    check_val("async_rst.gnt", 32'(gnt), 32'b0000);
    #1 rst_n = 1'b1; req = 4'b1111; i2 = 4'hC; #1;
    check_val("post_rst.gnt", 32'(gnt), 32'b0001);
    tick(); check_out("post_rst", 4'hA, 2'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
